xrisc_dmem_responder: RTL and testbench

- Memory-side responder for the single-cycle core's data-memory store interface (MemWrite/DataAdr/WriteData).
- Contains word-addressed data RAM with combinational read back to the core.
- Contains a sticky completion monitor: the program signals PASS by storing DONE_DATA to DONE_ADDR; any bad store or a timeout signals FAIL.
- Sits beside the core inside top; its done/pass status drives simulation end checks and FPGA LEDs.

---
 rtl/xrisc_dmem_responder.sv | 59 +++++
 tb/tb_xrisc_dmem_responder.sv | 120 ++++++++++++
 2 files changed

// File: rtl/xrisc_dmem_responder.sv
// xrisc_dmem_responder: word-addressed data RAM with a sticky pass/fail completion monitor on the core's store port
module xrisc_dmem_responder #(
  parameter int DEPTH = 64,
  parameter logic [31:0] DONE_ADDR = 32'd100,
  parameter logic [31:0] DONE_DATA = 32'd25,
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        done,
  output logic        pass,
  output logic [1:0]  fail_code,
  output logic [15:0] store_count,
  output logic [15:0] cycle_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] RUN = 2'd0, PASS = 2'd1, FAIL = 2'd2;
  logic [1:0] state;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic in_range, aligned, run, mbox, wr, cnt;
  assign idx = DataAdr[AW+1:2];
  assign in_range = DataAdr < 32'(DEPTH * 4);
  assign aligned = DataAdr[1:0] == 2'b00;
  assign run = state == RUN;
  assign mbox = DataAdr == DONE_ADDR;
  assign wr = MemWrite && run && aligned && in_range && !reset;
  assign cnt = MemWrite && run && aligned && (in_range || mbox);
  assign ReadData = in_range && aligned ? mem[idx] : '0;
  assign done = state != RUN;
  assign pass = state == PASS;
  always_ff @(posedge clk)
    if (wr) mem[idx] <= WriteData;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      fail_code <= 2'd0;
      store_count <= '0;
      cycle_count <= '0;
    end else if (run) begin
      cycle_count <= cycle_count + 16'd1;
      if (cnt && store_count != 16'hFFFF) store_count <= store_count + 16'd1;
      if (MemWrite && !aligned) begin
        state <= FAIL;
        fail_code <= 2'd2;
      end else if (MemWrite && mbox) begin
        state <= WriteData == DONE_DATA ? PASS : FAIL;
        fail_code <= WriteData == DONE_DATA ? 2'd0 : 2'd1;
      end else if (cycle_count == TIMEOUT - 16'd1) begin
        state <= FAIL;
        fail_code <= 2'd3;
      end
    end
  end
endmodule

// File: tb/tb_xrisc_dmem_responder.sv
// tb_xrisc_dmem_responder: random and directed stores checked by a queue scoreboard against a behavioural model
module tb_xrisc_dmem_responder;
  localparam int TO = 16;
  logic clk = 0, reset = 1, MemWrite = 0;
  logic [31:0] DataAdr = 0, WriteData = 0, ReadData;
  logic done, pass;
  logic [1:0] fail_code;
  logic [15:0] store_count, cycle_count;
  int total = 0, bad = 0;
  typedef struct {
    bit rd_chk;
    logic [31:0] rd;
    logic done, pass;
    logic [1:0] fc;
    logic [15:0] sc, cc;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [31:0] mram [64];
  bit known [64];
  bit m_done = 0, m_pass = 0;
  logic [1:0] m_fc = 0;
  int m_sc = 0, m_cc = 0;
  always #5 clk = ~clk;
  xrisc_dmem_responder #(.TIMEOUT(16'(TO))) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .ReadData(ReadData), .done(done), .pass(pass),
    .fail_code(fail_code), .store_count(store_count), .cycle_count(cycle_count)
  );
  task automatic chk(string n, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, act, want, $time);
    end
  endtask
  task automatic drive(bit r, bit mw, logic [31:0] a, logic [31:0] wd);
    exp_t x;
    bit al, inr;
    int w;
    @(negedge clk);
    reset = r; MemWrite = mw; DataAdr = a; WriteData = wd;
    al = a[1:0] == 2'b00;
    inr = a < 32'd256;
    w = inr ? int'(a >> 2) : 0;
    if (r) begin
      m_done = 0; m_pass = 0; m_fc = 0; m_sc = 0; m_cc = 0;
    end else if (!m_done) begin
      if (mw && al && inr) begin
        mram[w] = wd;
        known[w] = 1;
      end
      if (mw && al && (inr || a == 32'd100) && m_sc < 65535) m_sc++;
      if (mw && !al) begin
        m_done = 1; m_fc = 2;
      end else if (mw && a == 32'd100) begin
        m_done = 1; m_pass = wd == 32'd25; m_fc = m_pass ? 2'd0 : 2'd1;
      end else if (m_cc == TO - 1) begin
        m_done = 1; m_fc = 3;
      end
      m_cc++;
    end
    x.rd_chk = !(al && inr) || known[w];
    x.rd = (al && inr) ? mram[w] : 32'd0;
    x.done = m_done; x.pass = m_pass; x.fc = m_fc;
    x.sc = 16'(m_sc); x.cc = 16'(m_cc);
    q.push_back(x);
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      if (e.rd_chk) chk("rdata", ReadData, e.rd);
      chk("done", 32'(done), 32'(e.done));
      chk("pass", 32'(pass), 32'(e.pass));
      chk("fail_code", 32'(fail_code), 32'(e.fc));
      chk("store_count", 32'(store_count), 32'(e.sc));
      chk("cycle_count", 32'(cycle_count), 32'(e.cc));
    end
  end
  initial begin
    int k;
    logic [31:0] a, d;
    drive(1, 0, 0, 0); drive(1, 0, 0, 0);
    drive(0, 1, 32'h10, 32'hDEADBEEF); drive(0, 0, 32'h10, 0);
    drive(0, 1, 100, 25); drive(0, 1, 32'h20, 7); drive(0, 0, 32'h20, 0);
    drive(1, 0, 0, 0); drive(0, 1, 32'h20, 32'h1111); drive(0, 1, 100, 26); drive(0, 0, 100, 0);
    drive(1, 0, 0, 0); drive(0, 1, 32'h22, 5); drive(0, 0, 32'h20, 0);
    drive(1, 0, 0, 0);
    repeat (TO + 2) drive(0, 0, 32'h10, 0);
    drive(1, 0, 0, 0);
    repeat (TO - 1) drive(0, 0, 0, 0);
    drive(0, 1, 100, 25); drive(0, 0, 100, 0);
    drive(1, 0, 0, 0); drive(0, 1, 32'h400, 32'hAA); drive(0, 0, 32'h10, 0);
    drive(1, 1, 32'h10, 32'h12345678); drive(0, 0, 32'h10, 0);
    repeat (1500) begin
      k = $urandom_range(99);
      d = $urandom;
      if ($urandom_range(99) < 3) drive(1, $urandom_range(1), 32'($urandom_range(63)) << 2, d);
      else if (k < 50) drive(0, 1, 32'($urandom_range(63)) << 2, d);
      else if (k < 58) drive(0, 1, 32'h100 + (32'($urandom_range(1000)) << 2), d);
      else if (k < 61) begin
        a = 32'($urandom_range(255));
        a[1:0] = 2'($urandom_range(1, 3));
        drive(0, 1, a, d);
      end else if (k < 64) drive(0, 1, 100, $urandom_range(1) ? 32'd25 : d);
      else drive(0, 0, 32'($urandom_range(70)) << 2, d);
    end
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
